// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle LEGv8 control FSM with imem/dmem ready handshakes
// Optional PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_control #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [10:0]        opcode,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pc_src,
  output logic               reg2loc,
  output logic               alusrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         signop,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic               mem2reg,
  output logic               regwrite,
  output logic               illegal,
  output logic               mem_fault,
  output logic [2:0]         state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
`endif
);

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
    C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR, C_ILL
  } cls_t;

  // Priority matters: earlier classes shadow later overlapping patterns.
  function automatic cls_t classify(input logic [10:0] op);
    cls_t c;
    if      (op ==? 11'b?0001010???) c = C_AND;
    else if (op ==? 11'b?0101010???) c = C_ORR;
    else if (op ==? 11'b?0?01011???) c = C_ADD;
    else if (op ==? 11'b?1?01011???) c = C_SUB;
    else if (op ==? 11'b?0?10001???) c = C_ADDI;
    else if (op ==? 11'b?1?10001???) c = C_SUBI;
    else if (op ==? 11'b110100101??) c = C_MOVZ;
    else if (op ==? 11'b?00101?????) c = C_B;
    else if (op ==? 11'b?011010????) c = C_CBZ;
    else if (op ==? 11'b??111000010) c = C_LDUR;
    else if (op ==? 11'b??111000000) c = C_STUR;
    else                             c = C_ILL;
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [10:0]         opcode_q;
  logic [WAIT_W-1:0]   wait_cnt;
  cls_t                cls_d, cls_q;
  logic                waiting, timeout;
  logic [3:0]          alu4;

  assign cls_d   = classify(opcode);
  assign cls_q   = classify(opcode_q);
  assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                   ((state_q == S_MEM)   && !dmem_ready);
  assign timeout = waiting && (wait_cnt == WAIT_W'(WAIT_MAX));
  assign state   = state_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      opcode_q  <= '0;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (waiting && !timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                     wait_cnt <= '0;
      if (timeout) mem_fault <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
      S_DECODE: state_d = (cls_d == C_ILL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (cls_q == C_B || cls_q == C_CBZ)         state_d = S_FETCH;
        else if (cls_q == C_LDUR || cls_q == C_STUR) state_d = S_MEM;
        else                                        state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    alu4       = 4'b0000;
    signop     = 3'b000;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        irwrite  = imem_ready;
        pcwrite  = imem_ready;
      end
      S_DECODE: illegal = (cls_d == C_ILL);
      S_EXEC: begin
        case (cls_q)
          C_AND:  alu4 = 4'b0000;
          C_ORR:  alu4 = 4'b0001;
          C_ADD:  alu4 = 4'b0010;
          C_SUB:  alu4 = 4'b0110;
          C_ADDI: begin alu4 = 4'b0010; alusrc = 1'b1; end
          C_SUBI: begin alu4 = 4'b0110; alusrc = 1'b1; end
          C_MOVZ: begin alu4 = 4'b0111; alusrc = 1'b1; signop = 3'b100; end
          C_B: begin
            signop  = 3'b010;
            pcwrite = 1'b1;
            pc_src  = 1'b1;
          end
          C_CBZ: begin
            alu4    = 4'b0111;
            signop  = 3'b011;
            reg2loc = 1'b1;
            pcwrite = zero;
            pc_src  = zero;
          end
          C_LDUR: begin alu4 = 4'b0010; alusrc = 1'b1; signop = 3'b001; end
          C_STUR: begin
            alu4    = 4'b0010;
            alusrc  = 1'b1;
            signop  = 3'b001;
            reg2loc = 1'b1;
          end
          default: alu4 = 4'b0000;
        endcase
      end
      S_MEM: begin
        // Address stays on the ALU output for the whole access.
        alusrc     = 1'b1;
        alu4       = 4'b0010;
        dmem_read  = (cls_q == C_LDUR);
        dmem_write = (cls_q == C_STUR);
      end
      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls_q == C_LDUR);
      end
      default: imem_req = 1'b0;
    endcase
    aluop = ALUOP_W'(alu4);
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH) && !timeout && !illegal;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
